// File: rtl/window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous rows; out-of-image neighbours are zeroed at the output.
module window_gen #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [23:0]                 pix_in,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [23:0]                 colour_o0,
    output logic [23:0]                 colour_o1,
    output logic [23:0]                 colour_o2,
    output logic [23:0]                 colour_o3,
    output logic [23:0]                 colour_o4,
    output logic [23:0]                 colour_o5,
    output logic [23:0]                 colour_o6,
    output logic [23:0]                 colour_o7,
    output logic [23:0]                 colour_o8,
    output logic                        win_valid,
    output logic [$clog2(WIDTH)-1:0]    win_x,
    output logic [$clog2(HEIGHT)-1:0]   win_y,
    output logic                        busy,
    output logic                        done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int NW = $clog2(WIDTH * HEIGHT + WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t          state;
    logic [XW-1:0]   in_x;
    logic [NW-1:0]   pix_cnt;
    logic [XW-1:0]   out_x;
    logic [YW-1:0]   out_y;

    logic [23:0]     lb0 [WIDTH];
    logic [23:0]     lb1 [WIDTH];
    logic [23:0]     col_m [3];
    logic [23:0]     col_r [3];

    logic            accept;
    logic            flush_step;
    logic            shift;
    logic            emit;
    logic [23:0]     pix_eff;
    logic [23:0]     up_new;
    logic [23:0]     mid_new;
    logic            top_ok;
    logic            bot_ok;
    logic            lft_ok;
    logic            rgt_ok;

    function automatic logic [23:0] mask_px(input logic [23:0] v, input logic keep);
        return keep ? v : 24'h000000;
    endfunction

    always_comb begin
        accept     = pix_valid && pix_ready;
        flush_step = (state == S_FLUSH);
        shift      = accept || flush_step;
        emit       = (state == S_RUN && accept) || flush_step;
        pix_eff    = flush_step ? 24'h000000 : pix_in;
        up_new     = lb1[in_x];
        mid_new    = lb0[in_x];
        top_ok     = (out_y != '0);
        bot_ok     = (out_y != YW'(HEIGHT - 1));
        lft_ok     = (out_x != '0);
        rgt_ok     = (out_x != XW'(WIDTH - 1));
    end

    // Pixel storage: line buffers and the two newest window columns, no reset needed
    always_ff @(posedge clock) begin
        if (shift) begin
            lb1[in_x] <= mid_new;
            lb0[in_x] <= pix_eff;
            col_m     <= col_r;
            col_r[0]  <= up_new;
            col_r[1]  <= mid_new;
            col_r[2]  <= pix_eff;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            in_x      <= '0;
            pix_cnt   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            win_x     <= '0;
            win_y     <= '0;
            colour_o0 <= '0;
            colour_o1 <= '0;
            colour_o2 <= '0;
            colour_o3 <= '0;
            colour_o4 <= '0;
            colour_o5 <= '0;
            colour_o6 <= '0;
            colour_o7 <= '0;
            colour_o8 <= '0;
        end else begin
            win_valid <= emit;

            if (shift) begin
                in_x    <= (in_x == XW'(WIDTH - 1)) ? '0 : in_x + XW'(1);
                pix_cnt <= pix_cnt + NW'(1);
            end

            // The window centre trails the input by one row and one column
            if (emit) begin
                colour_o0 <= mask_px(col_m[0], top_ok && lft_ok);
                colour_o1 <= mask_px(col_r[0], top_ok);
                colour_o2 <= mask_px(up_new,   top_ok && rgt_ok);
                colour_o3 <= mask_px(col_m[1], lft_ok);
                colour_o4 <= col_r[1];
                colour_o5 <= mask_px(mid_new,  rgt_ok);
                colour_o6 <= mask_px(col_m[2], bot_ok && lft_ok);
                colour_o7 <= mask_px(col_r[2], bot_ok);
                colour_o8 <= mask_px(pix_eff,  bot_ok && rgt_ok);
                win_x     <= out_x;
                win_y     <= out_y;
                if (out_x == XW'(WIDTH - 1)) begin
                    out_x <= '0;
                    out_y <= out_y + YW'(1);
                end else begin
                    out_x <= out_x + XW'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FILL;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        in_x      <= '0;
                        pix_cnt   <= '0;
                        out_x     <= '0;
                        out_y     <= '0;
                    end
                end
                S_FILL: begin
                    if (accept && pix_cnt == NW'(WIDTH))
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (accept && pix_cnt == NW'(WIDTH * HEIGHT - 1)) begin
                        state     <= S_FLUSH;
                        pix_ready <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (pix_cnt == NW'(WIDTH * HEIGHT + WIDTH)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen on a 4x3 frame whose pixel values equal their raster index.
module tb_window_gen;
    localparam int W = 4;
    localparam int H = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] colour_o0, colour_o1, colour_o2, colour_o3, colour_o4;
    logic [23:0] colour_o5, colour_o6, colour_o7, colour_o8;
    logic        win_valid;
    logic [1:0]  win_x;
    logic [1:0]  win_y;
    logic        busy;
    logic        done;

    window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .colour_o0(colour_o0), .colour_o1(colour_o1), .colour_o2(colour_o2),
        .colour_o3(colour_o3), .colour_o4(colour_o4), .colour_o5(colour_o5),
        .colour_o6(colour_o6), .colour_o7(colour_o7), .colour_o8(colour_o8),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]        x;
        logic [1:0]        y;
        logic [8:0][23:0]  c;
    } win_t;

    win_t exp_q[$];
    win_t cap_q[$];
    win_t last_w;
    win_t mon_w;
    win_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [23:0] px(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 24'h000000;
        return 24'(y * W + x);
    endfunction

    function automatic win_t model(input int k);
        win_t w;
        int x;
        int y;
        x = k % W;
        y = k / W;
        w = '0;
        w.x = 2'(x);
        w.y = 2'(y);
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                w.c[(dy + 1) * 3 + dx + 1] = px(x + dx, y + dy);
        return w;
    endfunction

    function automatic win_t dut_win();
        win_t w;
        w.x = win_x;
        w.y = win_y;
        w.c = {colour_o8, colour_o7, colour_o6, colour_o5, colour_o4,
               colour_o3, colour_o2, colour_o1, colour_o0};
        return w;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            last_w = '0;
        end else if (win_valid) begin
            mon_w = dut_win();
            cap_q.push_back(mon_w);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_window: got %h expected none", mon_w);
            end else begin
                mon_e = exp_q.pop_front();
                check("window", 256'(mon_w), 256'(mon_e));
            end
            last_w = mon_w;
        end else begin
            check("hold", 256'(dut_win()), 256'(last_w));
        end
    end

    task automatic run_frame(input bit gaps, input bit poke_start, input int n_pix);
        int idx;
        int cyc;
        bit sent;
        bit poked;
        idx   = 0;
        cyc   = 0;
        poked = 0;
        cap_q.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", 256'({busy, pix_ready}), 256'(2'b11));
        while (idx < n_pix && cyc < 500) begin
            cyc++;
            start = 1'b0;
            if (poke_start && idx == 8 && !poked) begin
                start = 1'b1;
                poked = 1;
            end
            if (pix_ready && !(gaps && $urandom_range(0, 2) == 0)) begin
                pix_valid = 1'b1;
                pix_in    = 24'(idx);
                if (idx >= W + 1) exp_q.push_back(model(idx - W - 1));
                if (idx == W * H - 1)
                    for (int k = W * H - W - 1; k < W * H; k++) exp_q.push_back(model(k));
                sent = 1;
            end else begin
                pix_valid = 1'b0;
                pix_in    = 24'hDEAD00 ^ 24'(cyc);
                sent = 0;
            end
            @(negedge clock);
            if (sent) idx++;
        end
        start     = 1'b0;
        pix_valid = 1'b0;
        check("pixels_accepted", 256'(idx), 256'(n_pix));
    endtask

    task automatic finish_frame();
        int cyc;
        bit ready_bad;
        cyc = 0;
        ready_bad = 0;
        while (!done && cyc < 100) begin
            if (pix_ready) ready_bad = 1;
            @(negedge clock);
            cyc++;
        end
        check("done_seen", 256'(done), 256'(1'b1));
        @(negedge clock);
        check("done_single_then_idle", 256'({done, busy}), 256'(2'b00));
        check("ready_low_in_flush", 256'(ready_bad), 256'(1'b0));
        check("window_count", 256'(cap_q.size()), 256'(W * H));
        check("queue_drained", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_hand();
        win_t e;
        if (cap_q.size() == W * H) begin
            e = '0;
            e.c[4] = 24'd0; e.c[5] = 24'd1; e.c[7] = 24'd4; e.c[8] = 24'd5;
            check("first_window_0_0", 256'(cap_q[0]), 256'(e));
            e = '0;
            e.x = 2'd1; e.y = 2'd1;
            e.c[0] = 24'd0; e.c[1] = 24'd1; e.c[2] = 24'd2;
            e.c[3] = 24'd4; e.c[4] = 24'd5; e.c[5] = 24'd6;
            e.c[6] = 24'd8; e.c[7] = 24'd9; e.c[8] = 24'd10;
            check("interior_window_1_1", 256'(cap_q[5]), 256'(e));
            e = '0;
            e.x = 2'd3; e.y = 2'd2;
            e.c[0] = 24'd6; e.c[1] = 24'd7; e.c[3] = 24'd10; e.c[4] = 24'd11;
            check("last_window_3_2", 256'(cap_q[11]), 256'(e));
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 24'h0;
        repeat (2) @(negedge clock);
        check("reset_outputs", 256'({pix_ready, win_valid, busy, done, dut_win()}), 256'(0));
        start = 1'b1;
        repeat (3) @(negedge clock);
        check("start_during_reset", 256'({busy, pix_ready}), 256'(0));
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        pix_valid = 1'b1;
        pix_in    = 24'h123456;
        @(negedge clock);
        check("idle_not_ready", 256'({pix_ready, busy, win_valid}), 256'(0));
        pix_valid = 1'b0;

        run_frame(0, 0, W * H);
        finish_frame();
        check_hand();

        run_frame(1, 1, W * H);
        finish_frame();
        check_hand();

        run_frame(0, 0, 7);
        #2;
        reset = 1'b1;
        #1;
        check("abort_pending", 256'(exp_q.size()), 256'(0));
        check("abort_reset", 256'({pix_ready, win_valid, busy, done, dut_win()}), 256'(0));
        exp_q.delete();
        last_w = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_frame(0, 0, W * H);
        finish_frame();
        check_hand();

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter WIDTH, default 160, meaning image width in pixels (minimum 3).
REQ-002 Parameter HEIGHT, default 120, meaning image height in pixels (minimum 3).
REQ-003 clock  input  1  single clock for all state, rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 start  input  1  begin one frame; sampled only in IDLE.
REQ-006 pix_in  input  24  raster-order pixel, {R[23:16],G[15:8],B[7:0]}.
REQ-007 pix_valid  input  1  pix_in is valid this cycle.
REQ-008 pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 colour_o0..colour_o8  output  24 each  3x3 window: row-major 0 1 2 / 3 4 5 / 6 7 8, centre colour_o4.
REQ-010 win_valid  output  1  one-cycle pulse: window outputs are new this cycle.
REQ-011 win_x  output  clog2(WIDTH)  centre column of the current window.
REQ-012 win_y  output  clog2(HEIGHT)  centre row of the current window.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the frame's last window.

Function
REQ-015 The block SHALL implement states IDLE, FILL, RUN, FLUSH and DONE.
REQ-016 IDLE: pix_ready=0; start=1 clears the pixel counters and moves to FILL on the next edge.
REQ-017 Acceptance SHALL occur only when pix_valid=1 and pix_ready=1 on the same edge; pix_valid alone is ignored.
REQ-018 The block SHALL store pixels in two WIDTH-entry line buffers plus a 3x3 register window, with no frame buffer.
REQ-019 FILL: pix_ready=1; the first WIDTH+1 accepted pixels produce no window; the block moves to RUN after the (WIDTH+1)th acceptance.
REQ-020 RUN: pix_ready=1; accepting raster index n produces, on the next cycle, win_valid=1 for centre index k=n-WIDTH-1, with win_x=k mod WIDTH and win_y=k div WIDTH.
REQ-021 After the WIDTH*HEIGHT-th acceptance the block SHALL enter FLUSH with pix_ready=0.
REQ-022 FLUSH: the block SHALL insert one virtual zero pixel per cycle for WIDTH+1 cycles, each producing one window, then enter DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 Each frame SHALL emit exactly WIDTH*HEIGHT windows, in raster order, with no duplicates.
REQ-025 Neighbours outside the image SHALL read as 24'h000000: win_x=0 zeroes o0,o3,o6; win_x=WIDTH-1 zeroes o2,o5,o8; win_y=0 zeroes o0,o1,o2; win_y=HEIGHT-1 zeroes o6,o7,o8.
REQ-026 Stale line-buffer data from a previous or aborted frame SHALL never appear in a window.
REQ-027 Window outputs, win_x and win_y SHALL be registered and SHALL hold their values between win_valid pulses.
REQ-028 Input stalls (pix_valid=0) SHALL delay window emission and SHALL NOT alter window contents.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 No arithmetic SHALL be performed on pixel data; channels pass through bit-exact.

Reset
REQ-031 Reset SHALL force the following, regardless of current state and including mid-frame:
- state IDLE
- pix_ready, win_valid, busy, done = 0
- all colour_o*, win_x, win_y = 0
- counters cleared
REQ-032 Line-buffer contents SHALL NOT require reset.

Verification (WIDTH=4, HEIGHT=3, pixel value = raster index)
REQ-033 Assert reset -> all outputs 0 and pix_ready=0; start with reset high -> no state change.
REQ-034 start, then stream with no gaps -> first win_valid on the cycle after the 6th acceptance, centre (0,0): o4=0, o5=1, o7=4, o8=5, all other windows zero.
REQ-035 Same frame, interior centre (1,1) -> o0..o8 = 0,1,2,4,5,6,8,9,10.
REQ-036 Same frame -> 12 windows in raster order; last window (3,2) is o0=6, o1=7, o3=10, o4=11, others 0; pix_ready=0 during FLUSH; one done pulse follows.
REQ-037 Random pix_valid gaps -> window sequence and values identical to the gap-free run.
REQ-038 Reset after the 7th acceptance, then start and a clean frame -> results match REQ-034 to REQ-036; start pulsed mid-frame -> ignored.
